// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data wins contention; a grant streak counter bounds fetch starvation and WAIT is timeout-guarded.
module mem_arbiter #(
    parameter int B_WIDTH      = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic [B_WIDTH-1:0]   i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [B_WIDTH/8-1:0] d_wbe,
    input  logic [31:0]          d_addr,
    input  logic [B_WIDTH-1:0]   d_wdata,
    output logic [B_WIDTH-1:0]   d_rdata,
    output logic                 d_ready,
    output logic                 bus_err,
    output logic                 m_en,
    output logic                 m_we,
    output logic [B_WIDTH/8-1:0] m_wbe,
    output logic [31:0]          m_addr,
    output logic [B_WIDTH-1:0]   m_wdata,
    input  logic [B_WIDTH-1:0]   m_rdata,
    input  logic                 m_valid
);
    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [3:0]    STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, next_state;

    logic          owner_i;
    logic          err;
    logic [3:0]    streak;
    logic [TW-1:0] tcnt;
    logic          grant_i;
    logic          grant_d;
    logic          timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        timeout_hit = 1'b0;
        m_en        = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        bus_err     = 1'b0;
        unique case (state)
            IDLE: begin
                grant_i = i_req && (!d_req || streak == STREAK_MAX);
                grant_d = d_req && !grant_i;
                if (grant_i || grant_d) next_state = ISSUE;
            end
            ISSUE: begin
                m_en       = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                // a response landing on the last allowed cycle still counts as a normal completion
                if (m_valid) begin
                    next_state = DONE;
                end else if (tcnt == TCNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                i_ready    = owner_i;
                d_ready    = !owner_i;
                bus_err    = err;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_i <= 1'b0;
            err     <= 1'b0;
            streak  <= '0;
            tcnt    <= '0;
            m_we    <= 1'b0;
            m_wbe   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (grant_i || grant_d) begin
                owner_i <= grant_i;
                m_we    <= grant_d && d_we;
                m_wbe   <= grant_d ? d_wbe : '0;
                m_addr  <= grant_i ? i_addr : d_addr;
                m_wdata <= grant_d ? d_wdata : '0;
                if (grant_d && i_req)
                    streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
                else
                    streak <= '0;
            end
            if (state == WAIT) begin
                if (m_valid || timeout_hit) begin
                    if (owner_i) i_rdata <= m_valid ? m_rdata : '0;
                    else         d_rdata <= m_valid ? m_rdata : '0;
                    err <= !m_valid;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
            if (state == DONE) begin
                tcnt    <= '0;
                err     <= 1'b0;
                m_we    <= 1'b0;
                m_wbe   <= '0;
                m_addr  <= '0;
                m_wdata <= '0;
            end
        end
    end

endmodule
